grey_counter_n: RTL and testbench

Parametrised multi-digit decimal counter using the team's 5-bit reflected digit code, one code per decimal digit. It is the next generation of the fixed 12-digit odometer. It adds:
- configurable digit count
- count enable
- up/down direction
- parallel load independent of reset
- wrap carry/borrow pulse
- illegal-code flag
- optional compare/match output

It sits between the tick source and the display/scan logic and drives the digit buses directly.

---
 rtl/grey_counter_n.sv | 162 ++++++++++++++++
 tb/tb_grey_counter_n.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/grey_counter_n.sv
// grey_counter_n
//   Multi-digit decimal up/down counter. Each decimal digit is held in the
//   5-bit reflected digit code (0=00000 1=00001 2=00011 3=00010 4=00110
//   5=00100 6=01100 7=01000 8=11000 9=10000); the other 22 codes are illegal.
//   Priority per cycle: reset > load > step > hold.
//
// Optional feature macro: GREY_CNT_MATCH_EN (adds i_match_val / o_match).
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset, loads i_init
//   i_init       reset value, digit k at [5k+4:5k]
//   i_en         count enable, one step per cycle
//   i_dir        1 = up, 0 = down
//   i_load       parallel load request (verbatim, illegal codes allowed)
//   i_load_val   value loaded by i_load
//   i_match_val  compare value                  (GREY_CNT_MATCH_EN only)
//   o_count      registered count
//   o_carry      registered one-cycle wrap pulse
//   o_invalid    some digit of o_count holds an illegal code
//   o_match      registered o_count == i_match_val (GREY_CNT_MATCH_EN only)
module grey_counter_n #(
    parameter int DIGITS = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [5*DIGITS-1:0]   i_init,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic                  i_load,
    input  logic [5*DIGITS-1:0]   i_load_val,
`ifdef GREY_CNT_MATCH_EN
    input  logic [5*DIGITS-1:0]   i_match_val,
    output logic                  o_match,
`endif
    output logic [5*DIGITS-1:0]   o_count,
    output logic                  o_carry,
    output logic                  o_invalid
);

    localparam logic [4:0] CODE_0 = 5'b00000;
    localparam logic [4:0] CODE_9 = 5'b10000;

    // Decimal value of a digit code; 4'hF marks an illegal code.
    function automatic logic [3:0] code_to_dec(input logic [4:0] code);
        case (code)
            5'b00000: code_to_dec = 4'd0;
            5'b00001: code_to_dec = 4'd1;
            5'b00011: code_to_dec = 4'd2;
            5'b00010: code_to_dec = 4'd3;
            5'b00110: code_to_dec = 4'd4;
            5'b00100: code_to_dec = 4'd5;
            5'b01100: code_to_dec = 4'd6;
            5'b01000: code_to_dec = 4'd7;
            5'b11000: code_to_dec = 4'd8;
            5'b10000: code_to_dec = 4'd9;
            default:  code_to_dec = 4'hF;
        endcase
    endfunction

    function automatic logic [4:0] dec_to_code(input logic [3:0] dec);
        case (dec)
            4'd0:    dec_to_code = 5'b00000;
            4'd1:    dec_to_code = 5'b00001;
            4'd2:    dec_to_code = 5'b00011;
            4'd3:    dec_to_code = 5'b00010;
            4'd4:    dec_to_code = 5'b00110;
            4'd5:    dec_to_code = 5'b00100;
            4'd6:    dec_to_code = 5'b01100;
            4'd7:    dec_to_code = 5'b01000;
            4'd8:    dec_to_code = 5'b11000;
            4'd9:    dec_to_code = 5'b10000;
            default: dec_to_code = 5'b00000;
        endcase
    endfunction

    logic [5*DIGITS-1:0] count_q;
    logic [5*DIGITS-1:0] count_step;
    logic [5*DIGITS-1:0] count_d;
    logic                carry_q;
    logic                carry_d;
    logic                wrap;
    logic                invalid;

    // Single-cycle ripple. 'prop' is the carry/borrow entering digit k; it
    // only survives past the top digit on a genuine all-9 / all-0 wrap, since
    // an illegal digit absorbs it (becoming 0) and a normal digit stops it.
    always_comb begin
        logic       prop;
        logic [3:0] dec;
        count_step = count_q;
        prop       = 1'b1;
        dec        = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dec = code_to_dec(count_q[5*k +: 5]);
            if (prop) begin
                if (dec == 4'hF) begin
                    count_step[5*k +: 5] = CODE_0;
                    prop                 = 1'b0;
                end else if (i_dir) begin
                    if (dec == 4'd9) begin
                        count_step[5*k +: 5] = CODE_0;
                    end else begin
                        count_step[5*k +: 5] = dec_to_code(dec + 4'd1);
                        prop                 = 1'b0;
                    end
                end else begin
                    if (dec == 4'd0) begin
                        count_step[5*k +: 5] = CODE_9;
                    end else begin
                        count_step[5*k +: 5] = dec_to_code(dec - 4'd1);
                        prop                 = 1'b0;
                    end
                end
            end
        end
        wrap = prop;
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_en) begin
            count_d = count_step;
            carry_d = wrap;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= i_init;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        invalid = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (code_to_dec(count_q[5*k +: 5]) == 4'hF) invalid = 1'b1;
        end
    end

`ifdef GREY_CNT_MATCH_EN
    // Compares the value being registered so the flag lines up with o_count.
    logic match_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) match_q <= 1'b0;
        else       match_q <= (count_d == i_match_val);
    end
    assign o_match = match_q;
`endif

    assign o_count   = count_q;
    assign o_carry   = carry_q;
    assign o_invalid = invalid;

endmodule

// File: tb/tb_grey_counter_n.sv
module tb_grey_counter_n;

    localparam int D = 3;
    localparam int W = 5 * D;

    typedef struct packed {
        logic [W-1:0] count;
        logic         carry;
        logic         inv;
        logic         match;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic [W-1:0] i_init = '0;
    logic         i_en = 1'b0;
    logic         i_dir = 1'b1;
    logic         i_load = 1'b0;
    logic [W-1:0] i_load_val = '0;
    logic [W-1:0] o_count;
    logic         o_carry;
    logic         o_invalid;
`ifdef GREY_CNT_MATCH_EN
    logic [W-1:0] i_match_val = '0;
    logic         o_match;
`endif

    grey_counter_n #(.DIGITS(D)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_init     (i_init),
        .i_en       (i_en),
        .i_dir      (i_dir),
        .i_load     (i_load),
        .i_load_val (i_load_val),
`ifdef GREY_CNT_MATCH_EN
        .i_match_val(i_match_val),
        .o_match    (o_match),
`endif
        .o_count    (o_count),
        .o_carry    (o_carry),
        .o_invalid  (o_invalid)
    );

    always #5 i_clk = ~i_clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   n     = 0;   // model decimal value while the count is legal
    exp_t sb[$];

    function automatic logic [4:0] code(input int d);
        case (d)
            0: code = 5'b00000;
            1: code = 5'b00001;
            2: code = 5'b00011;
            3: code = 5'b00010;
            4: code = 5'b00110;
            5: code = 5'b00100;
            6: code = 5'b01100;
            7: code = 5'b01000;
            8: code = 5'b11000;
            default: code = 5'b10000;
        endcase
    endfunction

    function automatic logic [W-1:0] enc(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[5*k +: 5] = code(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drive one cycle, push the expectation, then check it after the edge.
    task automatic apply(input logic rst, input logic ld, input logic en,
                         input logic dir, input logic [W-1:0] ini,
                         input logic [W-1:0] lv, input exp_t e);
        exp_t g;
        i_rst = rst; i_load = ld; i_en = en; i_dir = dir;
        i_init = ini; i_load_val = lv;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty observed 0 expected 1");
        end
        if (sb.size() > 0) begin
            g = sb.pop_front();
            assert (o_count === g.count) else begin
                n_err++;
                $error("FAIL count observed %h expected %h", o_count, g.count);
            end
            n_vec++;
            assert (o_carry === g.carry) else begin
                n_err++;
                $error("FAIL carry observed %b expected %b (count %h)", o_carry, g.carry, g.count);
            end
            n_vec++;
            assert (o_invalid === g.inv) else begin
                n_err++;
                $error("FAIL invalid observed %b expected %b (count %h)", o_invalid, g.inv, g.count);
            end
`ifdef GREY_CNT_MATCH_EN
            n_vec++;
            assert (o_match === g.match) else begin
                n_err++;
                $error("FAIL match observed %b expected %b (count %h)", o_match, g.match, g.count);
            end
`endif
        end
        i_rst = 1'b0; i_load = 1'b0; i_en = 1'b0;
    endtask

    function automatic logic match_of(input logic [W-1:0] c, input logic rst);
`ifdef GREY_CNT_MATCH_EN
        return !rst && (c == i_match_val);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset(input int v);
        exp_t e;
        n = v;
        e = '{count: enc(v), carry: 1'b0, inv: 1'b0, match: 1'b0};
        apply(1'b1, 1'b0, 1'b0, 1'b1, enc(v), '0, e);
    endtask

    task automatic do_load(input int v);
        exp_t e;
        n = v;
        e = '{count: enc(v), carry: 1'b0, inv: 1'b0, match: match_of(enc(v), 1'b0)};
        apply(1'b0, 1'b1, 1'b0, 1'b1, '0, enc(v), e);
    endtask

    task automatic do_step(input logic dir);
        exp_t e;
        logic c;
        if (dir) begin
            c = (n == 999);
            n = (n + 1) % 1000;
        end else begin
            c = (n == 0);
            n = (n + 999) % 1000;
        end
        e = '{count: enc(n), carry: c, inv: 1'b0, match: match_of(enc(n), 1'b0)};
        apply(1'b0, 1'b0, 1'b1, dir, '0, '0, e);
    endtask

    task automatic do_hold();
        exp_t e;
        e = '{count: enc(n), carry: 1'b0, inv: 1'b0, match: match_of(enc(n), 1'b0)};
        apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, e);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] bad;
        logic [W-1:0] fixed;
`ifdef GREY_CNT_MATCH_EN
        i_match_val = enc(12);
`endif
        // reset, then full up sweep 000 -> 999 -> 000
        do_reset(0);
        for (int i = 0; i < 1000; i++) do_step(1'b1);
        do_hold();
        do_hold();

        // load 100, count down through 000 to a 999 wrap
        do_load(100);
        for (int i = 0; i < 101; i++) do_step(1'b0);
        do_step(1'b0);

        // illegal digit 0 with higher digits 5,3 absorbs an up step
        bad   = {code(5), code(3), 5'b11111};
        fixed = {code(5), code(3), 5'b00000};
        e = '{count: bad, carry: 1'b0, inv: 1'b1, match: match_of(bad, 1'b0)};
        apply(1'b0, 1'b1, 1'b0, 1'b1, '0, bad, e);
        e = '{count: fixed, carry: 1'b0, inv: 1'b0, match: match_of(fixed, 1'b0)};
        apply(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, e);
        n = 530;
        do_step(1'b0);

        // illegal middle digit stops a down borrow there
        bad   = {code(7), 5'b10101, code(0)};
        fixed = {code(7), 5'b00000, code(9)};
        e = '{count: bad, carry: 1'b0, inv: 1'b1, match: match_of(bad, 1'b0)};
        apply(1'b0, 1'b1, 1'b0, 1'b0, '0, bad, e);
        e = '{count: fixed, carry: 1'b0, inv: 1'b0, match: match_of(fixed, 1'b0)};
        apply(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, e);

        // reset beats load and enable; then load beats enable
        e = '{count: enc(321), carry: 1'b0, inv: 1'b0, match: 1'b0};
        apply(1'b1, 1'b1, 1'b1, 1'b1, enc(321), enc(777), e);
        e = '{count: enc(777), carry: 1'b0, inv: 1'b0, match: match_of(enc(777), 1'b0)};
        apply(1'b0, 1'b1, 1'b1, 1'b1, enc(321), enc(777), e);
        n = 777;

        // direction toggling around 500 / 499
        do_load(500);
        for (int i = 0; i < 10; i++) do_step(i[0]);

        // up-wrap carry is a single-cycle pulse
        do_load(998);
        do_step(1'b1);
        do_step(1'b1);
        do_step(1'b1);

        // reset with i_init equal to the compare value: flag waits one cycle
        do_reset(12);
        do_hold();
        do_step(1'b1);

        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
        end
        n_vec++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
